// File: rtl/shift_seq.sv
// Sequencer between execute-stage issue and the iterative shift unit: decodes the
// opcode, kicks the shifter, waits out its latency and hands back the tagged result.
module shift_seq #(
  parameter int TAG_W    = 5,
  parameter bit MASK_AMT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             out_wake,
  output logic             sh_kick,
  output logic             sh_lshift,
  output logic             sh_unsigned,
  output logic [31:0]      sh_a,
  output logic [31:0]      sh_b,
  input  logic             sh_ready,
  input  logic             sh_ready_pre,
  input  logic [31:0]      sh_q
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KICK  = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        lshift_r;
  logic        unsigned_r;

  // Kick is suppressed by a same-cycle flush so an aborted op never reaches the shifter.
  assign sh_kick     = (state_r == KICK) && sh_ready && !flush;
  assign out_wake    = (state_r == WAIT) && sh_ready_pre;
  assign sh_a        = a_r;
  assign sh_b        = MASK_AMT ? {27'd0, b_r[4:0]} : b_r;
  assign sh_lshift   = lshift_r;
  assign sh_unsigned = unsigned_r;

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_err    <= 1'b0;
      out_q      <= 32'd0;
      out_tag    <= '0;
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      lshift_r   <= 1'b0;
      unsigned_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && !flush) begin
            a_r        <= in_a;
            b_r        <= in_b;
            out_tag    <= in_tag;
            lshift_r   <= (in_op == 2'b00);
            unsigned_r <= (in_op == 2'b01);
            in_ready   <= 1'b0;
            if (in_op == 2'b10) begin
              out_q     <= 32'd0;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state_r   <= DONE;
            end else begin
              state_r   <= KICK;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        KICK: begin
          if (flush) begin
            in_ready <= 1'b1;
            state_r  <= IDLE;
          end else if (sh_ready) begin
            state_r  <= WAIT;
          end else begin
            state_r  <= KICK;
          end
        end
        WAIT: begin
          if (flush) begin
            state_r   <= DRAIN;
          end else if (sh_ready) begin
            out_q     <= sh_q;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            state_r   <= WAIT;
          end
        end
        DRAIN: begin
          // The shifter cannot be aborted; its result is discarded when it lands.
          if (sh_ready) begin
            in_ready <= 1'b1;
            state_r  <= IDLE;
          end else begin
            state_r  <= DRAIN;
          end
        end
        DONE: begin
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r   <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq with a behavioural iterative shifter (n cycles busy per kick).
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready, out_err, out_wake;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b, out_q, sh_a, sh_b, sh_q;
  logic [4:0]  in_tag, out_tag;
  logic        sh_kick, sh_lshift, sh_unsigned, sh_ready, sh_ready_pre;
  logic [31:0] cnt;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  shift_seq #(.TAG_W(5), .MASK_AMT(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_q(out_q), .out_tag(out_tag), .out_err(out_err),
    .out_wake(out_wake), .sh_kick(sh_kick), .sh_lshift(sh_lshift), .sh_unsigned(sh_unsigned),
    .sh_a(sh_a), .sh_b(sh_b), .sh_ready(sh_ready), .sh_ready_pre(sh_ready_pre), .sh_q(sh_q)
  );

  // Shifter model: busy for sh_b cycles after a kick, ready_pre one cycle before ready.
  assign sh_ready     = (cnt == 32'd0);
  assign sh_ready_pre = (cnt == 32'd1);
  always @(posedge clk) begin
    if (reset) begin
      cnt  <= 32'd0;
      sh_q <= 32'd0;
    end else if (sh_kick) begin
      cnt <= sh_b;
      if (sh_lshift)        sh_q <= sh_a << sh_b;
      else if (sh_unsigned) sh_q <= sh_a >> sh_b;
      else                  sh_q <= $signed(sh_a) >>> sh_b;
    end else if (cnt != 32'd0) begin
      cnt <= cnt - 32'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    step();
    in_valid = 1'b0;
  endtask

  // Steps until out_valid (bounded); cyc is cycles since accept, -1 on timeout.
  task automatic wait_valid(output int cyc, output int wake_cyc);
    cyc = 1; wake_cyc = -1;
    while (!out_valid && cyc < 80) begin
      if (out_wake && wake_cyc < 0) wake_cyc = cyc;
      step();
      cyc++;
    end
    if (!out_valid) cyc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    compared++; if ({out_valid, out_err, out_wake, sh_kick} !== 4'b0000) begin mismatched++; $display("FAIL rst_flags got=%b exp=0000", {out_valid, out_err, out_wake, sh_kick}); end
    compared++; if (out_q !== 32'd0 || out_tag !== 5'd0) begin mismatched++; $display("FAIL rst_q_tag got=%h/%0d exp=0/0", out_q, out_tag); end
  endtask

  task automatic test_sll();
    int cyc, wk;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL sll_accept got=%b exp=1", in_ready); end
    issue(2'b00, 32'h0000_0001, 32'd4, 5'd3);
    compared++; if (sh_kick !== 1'b1 || in_ready !== 1'b0) begin mismatched++; $display("FAIL sll_kick got=%b%b exp=10", sh_kick, in_ready); end
    wait_valid(cyc, wk);
    compared++; if (cyc !== 7) begin mismatched++; $display("FAIL sll_latency got=%0d exp=7", cyc); end
    compared++; if (wk !== 5) begin mismatched++; $display("FAIL sll_wake got=%0d exp=5", wk); end
    compared++; if (out_q !== 32'h0000_0010 || out_tag !== 5'd3 || out_err !== 1'b0) begin mismatched++; $display("FAIL sll_result got=%h/%0d/%b exp=00000010/3/0", out_q, out_tag, out_err); end
    step();
    compared++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin mismatched++; $display("FAIL sll_idle got=%b%b exp=10", in_ready, out_valid); end
  endtask

  task automatic test_sra_srl();
    int cyc, wk;
    issue(2'b11, 32'h8000_0000, 32'd31, 5'd1);
    wait_valid(cyc, wk);
    compared++; if (out_q !== 32'hFFFF_FFFF || cyc !== 34) begin mismatched++; $display("FAIL sra31 got=%h@%0d exp=ffffffff@34", out_q, cyc); end
    step();
    issue(2'b01, 32'h8000_0000, 32'd31, 5'd2);
    wait_valid(cyc, wk);
    compared++; if (out_q !== 32'h0000_0001 || cyc !== 34) begin mismatched++; $display("FAIL srl31 got=%h@%0d exp=00000001@34", out_q, cyc); end
    step();
    issue(2'b01, 32'h8000_0000, 32'h0000_0025, 5'd4);
    compared++; if (sh_b !== 32'd5) begin mismatched++; $display("FAIL mask_amt got=%h exp=5", sh_b); end
    wait_valid(cyc, wk);
    compared++; if (out_q !== 32'h0400_0000 || cyc !== 8) begin mismatched++; $display("FAIL srl_masked got=%h@%0d exp=04000000@8", out_q, cyc); end
    step();
  endtask

  task automatic test_zero_amount();
    int cyc, wk;
    issue(2'b00, 32'hDEAD_BEEF, 32'd0, 5'd6);
    wait_valid(cyc, wk);
    compared++; if (out_q !== 32'hDEAD_BEEF || cyc !== 3) begin mismatched++; $display("FAIL zero_amt got=%h@%0d exp=deadbeef@3", out_q, cyc); end
    compared++; if (wk !== -1) begin mismatched++; $display("FAIL zero_wake got=%0d exp=-1", wk); end
    step();
  endtask

  task automatic test_reserved_backpressure();
    out_ready = 1'b0;
    issue(2'b10, 32'h1234_5678, 32'd3, 5'd7);
    for (int k = 1; k <= 5; k++) begin
      compared++;
      if (out_valid !== 1'b1 || out_q !== 32'd0 || out_err !== 1'b1 || in_ready !== 1'b0 || sh_kick !== 1'b0 || out_tag !== 5'd7) begin
        mismatched++; $display("FAIL rsv_hold c%0d got=v%b q%h e%b r%b k%b t%0d exp=v1 q0 e1 r0 k0 t7", k, out_valid, out_q, out_err, in_ready, sh_kick, out_tag);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    compared++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin mismatched++; $display("FAIL rsv_release got=%b%b exp=10", in_ready, out_valid); end
  endtask

  task automatic test_flush_wait();
    int cyc, wk;
    issue(2'b01, 32'hF000_0000, 32'd20, 5'd9);
    step(); step(); step(); step();
    flush = 1'b1; step(); flush = 1'b0;
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd3; in_b = 32'd2; in_tag = 5'd4;
    for (int k = 6; k <= 22; k++) begin
      compared++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin mismatched++; $display("FAIL drain c%0d got=%b%b exp=00", k, in_ready, out_valid); end
      step();
    end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL drain_exit got=%b exp=1", in_ready); end
    step(); in_valid = 1'b0;
    wait_valid(cyc, wk);
    compared++; if (out_q !== 32'd12 || out_tag !== 5'd4 || cyc !== 5) begin mismatched++; $display("FAIL after_flush got=%h/%0d@%0d exp=0000000c/4@5", out_q, out_tag, cyc); end
    step();
  endtask

  task automatic test_flush_done_idle();
    out_ready = 1'b0;
    issue(2'b10, 32'd0, 32'd0, 5'd2);
    step();
    flush = 1'b1; out_ready = 1'b1; step(); flush = 1'b0;
    compared++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL flush_done got=%b%b exp=01", out_valid, in_ready); end
    in_valid = 1'b1; in_op = 2'b00; in_b = 32'd1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    compared++; if (in_ready !== 1'b1 || sh_kick !== 1'b0) begin mismatched++; $display("FAIL flush_idle got=%b%b exp=10", in_ready, sh_kick); end
  endtask

  task automatic test_reset_mid_op();
    int cyc, wk;
    issue(2'b11, 32'h8000_0000, 32'd10, 5'd5);
    step(); step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    compared++; if ({in_ready, out_valid, out_err, out_wake, sh_kick} !== 5'b10000) begin mismatched++; $display("FAIL midrst_flags got=%b exp=10000", {in_ready, out_valid, out_err, out_wake, sh_kick}); end
    compared++; if (out_q !== 32'd0 || out_tag !== 5'd0) begin mismatched++; $display("FAIL midrst_q got=%h/%0d exp=0/0", out_q, out_tag); end
    issue(2'b01, 32'h0000_0100, 32'd8, 5'd11);
    wait_valid(cyc, wk);
    compared++; if (out_q !== 32'h0000_0001 || out_tag !== 5'd11 || cyc !== 11) begin mismatched++; $display("FAIL midrst_next got=%h/%0d@%0d exp=00000001/11@11", out_q, out_tag, cyc); end
    step();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = 32'd0; in_b = 32'd0;
    in_tag = 5'd0; flush = 1'b0; out_ready = 1'b1;
    test_reset();
    test_sll();
    test_sra_srl();
    test_zero_amount();
    test_reserved_backpressure();
    test_flush_wait();
    test_flush_done_idle();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
# shift_seq

Sequencer between the execute-stage issue logic and the iterative `shift` unit. It accepts one shift operation per transaction over a valid/ready handshake and translates the opcode into the shifter's `kick`/`lshift`/`unsigned_flag` controls. It waits out the variable shift latency, then presents the result with its destination tag over a second valid/ready handshake. It also handles flushes and gives the scheduler an early wake-up.

## Interface
- `TAG_W`, 5, width of destination register tag
- `MASK_AMT`, 1, 1: shift amount = `in_b[4:0]`; 0: full 32-bit `in_b` passed through
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  operation offered
- `in_ready`  out  1  sequencer can accept
- `in_op`  in  2  00 SLL, 01 SRL, 11 SRA, 10 reserved
- `in_a`  in  32  operand to shift
- `in_b`  in  32  shift amount source
- `in_tag`  in  TAG_W  destination tag
- `flush`  in  1  abort in-flight operation
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes result
- `out_q`  out  32  shifted result
- `out_tag`  out  TAG_W  tag of result
- `out_err`  out  1  result came from reserved opcode
- `out_wake`  out  1  result is 2 cycles from `out_valid`
- `sh_kick`, `sh_lshift`, `sh_unsigned`  out  1 each  to shifter
- `sh_a`, `sh_b`  out  32 each  to shifter
- `sh_ready`, `sh_ready_pre`  in  1 each  from shifter
- `sh_q`  in  32  from shifter

## Operation
- States: IDLE, KICK, WAIT, DRAIN, DONE.
- IDLE: `in_ready`=1.
  - On `in_valid & in_ready & !flush`, register `a`, the amount, the tag, and decode `lshift` = (op==00), `unsigned` = (op==01).
  - Op 10 goes directly to DONE with `out_q`=0 and `out_err`=1. The shifter is not kicked.
  - Other ops go to KICK.
- KICK: `sh_kick`=1 only while `sh_ready`=1. Stay in KICK while `sh_ready`=0. After the kick cycle, go to WAIT.
- WAIT:
  - When `sh_ready`=1, capture `sh_q` into `out_q` with `out_err`=0 and go to DONE.
  - `out_wake` = `sh_ready_pre` (WAIT only).
- DONE: `out_valid`=1, outputs stable. On `out_ready`, return to IDLE.
- `sh_a`, `sh_b`, `sh_lshift`, `sh_unsigned` are driven from the registered operands at all times.
- Amount rule:
  - `MASK_AMT`=1: `sh_b` = {27'b0, `b[4:0]`}.
  - `MASK_AMT`=0: `sh_b` = `in_b`. Amounts of 32 or more give 0 (SLL/SRL) or 32 copies of the sign bit (SRA).
- `flush`:
  - IDLE: input ignored that cycle; `in_ready` remains 1 but no accept.
  - KICK (kick not yet issued): go to IDLE.
  - WAIT: go to DRAIN. The shifter cannot be aborted.
  - DRAIN: no output; on `sh_ready` go to IDLE; `out_wake`=0.
  - DONE: drop the result and go to IDLE. `out_valid` is low the next cycle.
- `in_ready`=0 in all states except IDLE. There is no back-to-back overlap.

## Timing
- Reset values:
  - State = IDLE.
  - `out_valid`, `out_err`, `out_wake`, `sh_kick` = 0.
  - `out_q` = 0, `out_tag` = 0.
  - `in_ready` = 1.
- Reset mid-operation returns to IDLE immediately. The shifter shares the same reset, so `sh_ready`=1 afterward.
- Latency, with accept in cycle 0 and amount n:
  - Kick in cycle 1.
  - Shifter `ready` in cycle 2+n.
  - `out_valid` from cycle 3+n.
  - Total is 3+n cycles to result.
- Reserved op: `out_valid` in cycle 1.
- `out_wake` is high in cycle 1+n, when n≥1. It is never asserted for n=0.
- Throughput: one op per 4+n cycles when `out_ready` is held high. IDLE is entered on the cycle after the result is taken.
- Simultaneous `flush` and `out_ready` in DONE: the result is treated as not delivered, and IDLE is entered.

## Test plan
- SLL: a=0x0000_0001, b=4, tag=3, `out_ready`=1 -> `out_q`=0x0000_0010, `out_tag`=3, `out_valid` 7 cycles after accept, `out_wake` 2 cycles before.
- SRA vs SRL: a=0x8000_0000, b=31 -> SRA gives 0xFFFF_FFFF, SRL gives 0x0000_0001. With `MASK_AMT`=1 and b=0x25, SRL gives a>>5 = 0x0400_0000.
- Zero amount: a=0xDEAD_BEEF, b=0 -> `out_q`=0xDEAD_BEEF 3 cycles after accept, `out_wake` never high.
- Backpressure and reserved op: op=10 with `out_ready`=0 for 5 cycles -> `out_valid`=1 from cycle 1, stable with `out_q`=0 and `out_err`=1, `in_ready`=0 throughout. Release -> IDLE the next cycle.
- Flush in WAIT: b=20, flush in cycle 5 -> DRAIN, no `out_valid`. Next op accepted only after `sh_ready`, and it returns a correct result.
- Reset in cycle 4 of a b=10 op -> all outputs at reset values next cycle. A subsequent op completes normally.
